// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side signal bundle for fifo_wr_arbiter.
// master drives requests and full; slave is the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int GW    = $clog2(N_REQ)
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   fifo_full;
  logic                   fifo_wr_en;
  logic [WIDTH-1:0]       fifo_data;
  logic [GW-1:0]          grant_id;
  logic                   busy;

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_data,
    input  grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_data,
    output grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port.
// Registered arbitration, combinational handshake.
module fifo_wr_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int BURST = 4
) (
  input logic              clk,
  input logic              rst_n,
  fifo_wr_arbiter_if.slave bus
);
  localparam int GW = $clog2(N_REQ);
  localparam int BW = $clog2(BURST) + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_n;
  logic [GW-1:0]    owner, owner_n;
  logic [GW-1:0]    last, last_n;
  logic [BW-1:0]    beat, beat_n;
  logic [GW-1:0]    pick;
  logic             any;
  int               idx;
  logic             sel_valid;
  logic [WIDTH-1:0] sel_data;
  logic             xfer;
  logic [N_REQ-1:0] ready;
  logic             wr_en;
  logic [WIDTH-1:0] data;
  logic [GW-1:0]    gid;
  logic             busy;

  // first valid requester after the previous owner
  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!any && bus.req_valid[idx]) begin
        any  = 1'b1;
        pick = GW'(idx);
      end
    end
  end

  // mux the current owner's request
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (GW'(i) == owner) begin
        sel_valid = bus.req_valid[i];
        sel_data  = bus.req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // next state and handshake outputs
  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last;
    beat_n  = beat;
    ready   = '0;
    xfer    = 1'b0;
    wr_en   = 1'b0;
    data    = '0;
    gid     = '0;
    busy    = 1'b0;
    unique case (state)
      IDLE: begin
        if (any) begin
          owner_n = pick;
          beat_n  = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        busy         = 1'b1;
        gid          = owner;
        ready[owner] = !bus.fifo_full;
        xfer         = sel_valid && !bus.fifo_full;
        wr_en        = xfer;
        data         = xfer ? sel_data : '0;
        if (!sel_valid) begin
          state_n = IDLE;
          last_n  = owner;
          beat_n  = '0;
        end else if (xfer) begin
          if (beat == BW'(BURST - 1)) begin
            state_n = IDLE;
            last_n  = owner;
            beat_n  = '0;
          end else begin
            beat_n = beat + BW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // arbitration state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      last  <= GW'(N_REQ - 1);
      beat  <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      last  <= last_n;
      beat  <= beat_n;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.fifo_wr_en = wr_en;
  assign bus.fifo_data  = data;
  assign bus.grant_id   = gid;
  assign bus.busy       = busy;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and random bench for fifo_wr_arbiter.
// Producer queues plus an expected-write scoreboard.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int B  = 4;
  localparam int GW = $clog2(N);

  typedef struct packed {
    logic [GW-1:0] id;
    logic [W-1:0]  d;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fifo_wr_arbiter_if #(.N_REQ(N), .WIDTH(W)) ifc ();

  fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .BURST(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  exp_t         exp_q[$];
  logic [W-1:0] src[N][$];
  int           nxt[N];
  bit           en[N];
  bit           full;
  bit           use_exp;
  int           checks;
  int           failures;

  function automatic logic [W-1:0] word(int i, int k);
    return {8'(i), 24'(k)};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(int i, int n);
    for (int k = 0; k < n; k++) begin
      src[i].push_back(word(i, nxt[i]));
      nxt[i]++;
    end
  endtask

  task automatic expect_w(int i, int k0, int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.id = GW'(i);
      e.d  = word(i, k0 + k);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      ifc.req_valid[i] = en[i] && (src[i].size() != 0);
      ifc.req_data[i*W +: W] = (src[i].size() != 0) ? src[i][0] : '0;
    end
    ifc.fifo_full = full;
  endtask

  task automatic check_cycle();
    int           nacc;
    logic [W-1:0] w;
    exp_t         e;
    nacc = 0;
    w    = '0;
    chk("ready_onehot0", 64'($onehot0(ifc.req_ready)), 64'd1);
    chk("wr_on_full", 64'(ifc.fifo_wr_en & ifc.fifo_full), 64'd0);
    for (int i = 0; i < N; i++) begin
      if (ifc.req_valid[i] && ifc.req_ready[i]) begin
        nacc++;
        w = src[i].pop_front();
      end
    end
    chk("wr_vs_accept", 64'(ifc.fifo_wr_en), 64'(nacc != 0));
    if (nacc != 0) chk("fifo_data", 64'(ifc.fifo_data), 64'(w));
    if (use_exp && ifc.fifo_wr_en === 1'b1) begin
      chk("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_data", 64'(ifc.fifo_data), 64'(e.d));
        chk("sb_grant_id", 64'(ifc.grant_id), 64'(e.id));
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      en[i]  = 1'b0;
      nxt[i] = 0;
      src[i].delete();
    end
    exp_q.delete();
    full = 1'b0;
    drive();
  endtask

  task automatic do_reset();
    clear_all();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_busy"}, 64'(ifc.busy), 64'd0);
    chk({tag, "_ready"}, 64'(ifc.req_ready), 64'd0);
    chk({tag, "_wr_en"}, 64'(ifc.fifo_wr_en), 64'd0);
    chk({tag, "_data"}, 64'(ifc.fifo_data), 64'd0);
    chk({tag, "_gid"}, 64'(ifc.grant_id), 64'd0);
  endtask

  bit t2_busy[10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
  bit t2_wr[10]   = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
  bit t4_full[9]  = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
  bit t4_busy[9]  = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
  bit t4_wr[9]    = '{0, 1, 1, 0, 0, 0, 1, 1, 0};

  initial begin
    checks   = 0;
    failures = 0;
    use_exp  = 1'b1;
    clear_all();

    // T1: reset values, then async reset mid-burst
    repeat (2) @(negedge clk);
    chk_all_zero("t1_in_reset");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    load(2, 3);
    en[2] = 1'b1;
    expect_w(2, 0, 1);
    cyc();
    chk("t1_idle_busy", 64'(ifc.busy), 64'd0);
    cyc();
    chk("t1_grant_busy", 64'(ifc.busy), 64'd1);
    chk("t1_grant_id", 64'(ifc.grant_id), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("t1_async");
    clear_all();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t1_post_busy", 64'(ifc.busy), 64'd0);
    end

    // T2: single requester, 6 words, burst of 4 then 2
    do_reset();
    load(1, 6);
    en[1] = 1'b1;
    expect_w(1, 0, 6);
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("t2_busy", 64'(ifc.busy), 64'(t2_busy[k]));
      chk("t2_wr", 64'(ifc.fifo_wr_en), 64'(t2_wr[k]));
    end
    chk("t2_drained", 64'(exp_q.size()), 64'd0);

    // T3: all requesters valid, round-robin order 0,1,2,3,0,...
    do_reset();
    for (int i = 0; i < N; i++) begin
      load(i, 8);
      en[i] = 1'b1;
    end
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++)
        expect_w(i, r * B, B);
    for (int k = 0; k < 42; k++) begin
      cyc();
      chk("t3_busy", 64'(ifc.busy), 64'((k % 5 != 0) && (k < 40)));
    end
    chk("t3_drained", 64'(exp_q.size()), 64'd0);

    // T4: fifo_full for 3 cycles after beat 2
    do_reset();
    load(0, 6);
    expect_w(0, 0, 4);
    for (int k = 0; k < 9; k++) begin
      full  = t4_full[k];
      en[0] = (k < 8);
      cyc();
      chk("t4_busy", 64'(ifc.busy), 64'(t4_busy[k]));
      chk("t4_wr", 64'(ifc.fifo_wr_en), 64'(t4_wr[k]));
      if (t4_full[k]) chk("t4_ready", 64'(ifc.req_ready), 64'd0);
    end
    chk("t4_drained", 64'(exp_q.size()), 64'd0);
    chk("t4_left", 64'(src[0].size()), 64'd2);

    // T5: owner drops valid, re-raise served after req2 and req3
    do_reset();
    load(0, 6);
    load(2, 4);
    load(3, 2);
    en[0] = 1'b1;
    en[2] = 1'b1;
    expect_w(0, 0, 2);
    expect_w(2, 0, 4);
    expect_w(3, 0, 2);
    expect_w(0, 2, 4);
    cyc();
    cyc();
    cyc();
    chk("t5_owner0", 64'(ifc.grant_id), 64'd0);
    en[0] = 1'b0;
    cyc();
    chk("t5_drop_busy", 64'(ifc.busy), 64'd1);
    chk("t5_drop_wr", 64'(ifc.fifo_wr_en), 64'd0);
    en[0] = 1'b1;
    en[3] = 1'b1;
    cyc();
    chk("t5_bubble", 64'(ifc.busy), 64'd0);
    cyc();
    chk("t5_next_id2", 64'(ifc.grant_id), 64'd2);
    for (int k = 6; k < 19; k++) cyc();
    chk("t5_drained", 64'(exp_q.size()), 64'd0);
    chk("t5_req0_done", 64'(src[0].size()), 64'd0);

    // T6: random valid/full traffic
    do_reset();
    use_exp = 1'b0;
    for (int k = 0; k < 10000; k++) begin
      for (int i = 0; i < N; i++) begin
        if (src[i].size() < 2) load(i, 4);
        en[i] = ($urandom_range(0, 3) != 0);
      end
      full = ($urandom_range(0, 3) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
